// File: rtl/mem_port_arbiter_if.sv
// Request/grant/rvalid memory port bundle shared by the arbiter's requester and memory sides.
// master drives the address phase; slave answers with gnt and the rvalid/rdata response.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (p0 = data cache, p1 = instruction fetch) onto one req/gnt/rvalid memory port.
// Define ARB_FIXED_PRIO_EN to give p0 fixed priority instead of round-robin.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 22,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   p0,
  mem_port_arbiter_if.slave   p1,
  mem_port_arbiter_if.master  mem,
  output logic                resp_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    LK_OPEN,
    LK_HELD
  } lock_state_e;

  // Owner FIFO: one bit per granted-but-unanswered transaction, naming the issuing port.
  logic             owner_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  lock_state_e lock_state_q, lock_state_d;
  logic        lock_port_q, lock_port_d;
  logic        resp_err_q;
`ifndef ARB_FIXED_PRIO_EN
  logic        rr_ptr_q;
`endif

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  can_issue;
  logic                  sel;
  logic                  sel_req;
  logic                  issue;
  logic                  grant;
  logic                  push;
  logic                  pop;
  logic                  head;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [3:0]            sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO may still accept a grant when a response frees the head slot this cycle.
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign can_issue  = !reset && (!fifo_full || mem.rvalid);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel = 1'b0;
    if (lock_state_q == LK_HELD) begin
      sel = lock_port_q;
    end else if (p0.req && !p1.req) begin
      sel = 1'b0;
    end else if (!p0.req && p1.req) begin
      sel = 1'b1;
    end else if (p0.req && p1.req) begin
`ifdef ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = rr_ptr_q;
`endif
    end
  end

  assign sel_req = !reset && (sel ? p1.req : p0.req);
  assign issue   = can_issue && sel_req;
  assign grant   = issue && mem.gnt;
  assign push    = grant;
  assign pop     = !reset && mem.rvalid && !fifo_empty;
  assign head    = owner_mem[rd_ptr_q];

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    if (sel_req) begin
      sel_addr  = sel ? p1.addr  : p0.addr;
      sel_we    = sel ? p1.we    : p0.we;
      sel_be    = sel ? p1.be    : p0.be;
      sel_wdata = sel ? p1.wdata : p0.wdata;
    end
  end

  assign mem.req   = issue;
  assign mem.addr  = sel_addr;
  assign mem.we    = sel_we;
  assign mem.be    = sel_be;
  assign mem.wdata = sel_wdata;

  assign p0.gnt    = grant && !sel;
  assign p1.gnt    = grant &&  sel;
  assign p0.rvalid = pop && !head;
  assign p1.rvalid = pop &&  head;
  // rdata is broadcast; only the per-port rvalid qualifies it.
  assign p0.rdata  = reset ? '0 : mem.rdata;
  assign p1.rdata  = reset ? '0 : mem.rdata;
  assign resp_err  = resp_err_q;

  // Lock holds the selected port while memory stalls, keeping the address phase stable.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_port_d  = lock_port_q;
    if (grant) begin
      lock_state_d = LK_OPEN;
    end else if (issue) begin
      lock_state_d = LK_HELD;
      lock_port_d  = sel;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state_q <= LK_OPEN;
      lock_port_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_port_q  <= lock_port_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      resp_err_q <= mem.rvalid && fifo_empty;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset)      rr_ptr_q <= 1'b0;
    else if (grant) rr_ptr_q <= ~sel;
  end
`endif

  // NOTE: the owner storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) owner_mem[wr_ptr_q] <= sel;
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset) !(p0.gnt && p1.gnt));
  a_no_overflow : assert property (@(posedge clk) disable iff (reset) (push && !pop) |-> !fifo_full);
  a_rvalid_onehot : assert property (@(posedge clk) disable iff (reset) !(p0.rvalid && p1.rvalid));

endmodule
